// File: rtl/mod5_counter.sv
// Enable-driven modulo-5 counter as a 5-state Moore FSM.
// Count and raw state are decoded from the state register only.
module mod5_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       w,
    output logic [2:0] count,
    output logic [2:0] state
);

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S0 = 3'b000,
        S1 = 3'b001,
        S2 = 3'b010,
        S3 = 3'b011,
        S4 = 3'b100
    } state_e;

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;

    // Next-state: advance on w, hold otherwise; illegal encodings recover to S0.
    always_comb begin
        state_d = S0;
        case (state_q)
            S0:      state_d = w ? S1 : S0;
            S1:      state_d = w ? S2 : S1;
            S2:      state_d = w ? S3 : S2;
            S3:      state_d = w ? S4 : S3;
            S4:      state_d = w ? S0 : S4;
            default: state_d = S0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S0;
        end else begin
            state_q <= state_d;
        end
    end

    // Moore decode; illegal encodings read as zero.
    always_comb begin
        state = state_q;
        count = (state_q <= STATE_W'(S4)) ? state_q : STATE_W'(0);
    end

endmodule

// File: tb/tb_mod5_counter.sv
// Self-checking bench for mod5_counter using an expected-value queue.
module tb_mod5_counter;

    logic       clk;
    logic       rst;
    logic       w;
    logic [2:0] count;
    logic [2:0] state;

    int n_checks;
    int n_fail;

    // Each entry: {expected count, expected state}
    logic [5:0] exp_q[$];

    mod5_counter dut (
        .clk   (clk),
        .rst   (rst),
        .w     (w),
        .count (count),
        .state (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive inputs at negedge, then sample #1 after the next rising edge.
    task automatic step(input logic r, input logic wv);
        @(negedge clk);
        rst = r;
        w   = wv;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [5:0] e;
        exp_q.push_back({3'd0, 3'b000});
        step(1'b1, 1'b0);
        e = exp_q.pop_front();
        n_checks++;
        if (count !== e[5:3]) begin
            n_fail++;
            $display("FAIL reset_count: got %0d expected %0d", count, e[5:3]);
        end
        n_checks++;
        if (state !== e[2:0]) begin
            n_fail++;
            $display("FAIL reset_state: got %b expected %b", state, e[2:0]);
        end
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back({3'd0, 3'b000});
            step(1'b0, 1'b0);
            e = exp_q.pop_front();
            n_checks++;
            if (count !== e[5:3]) begin
                n_fail++;
                $display("FAIL idle_count[%0d]: got %0d expected %0d", i, count, e[5:3]);
            end
        end
    endtask

    task automatic test_wrap();
        logic [5:0] e;
        logic [2:0] exp_cnt[5];
        exp_cnt = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back({exp_cnt[i], exp_cnt[i]});
            step(1'b0, 1'b1);
            e = exp_q.pop_front();
            n_checks++;
            if (count !== e[5:3]) begin
                n_fail++;
                $display("FAIL wrap_count[%0d]: got %0d expected %0d", i, count, e[5:3]);
            end
            n_checks++;
            if (state !== e[2:0]) begin
                n_fail++;
                $display("FAIL wrap_state[%0d]: got %b expected %b", i, state, e[2:0]);
            end
        end
    endtask

    task automatic test_hold();
        logic [5:0] e;
        // From 0, advance to 2, hold for 4 edges, then advance to 3.
        exp_q.push_back({3'd1, 3'b001});
        exp_q.push_back({3'd2, 3'b010});
        for (int i = 0; i < 4; i++) exp_q.push_back({3'd2, 3'b010});
        exp_q.push_back({3'd3, 3'b011});
        for (int i = 0; i < 7; i++) begin
            step(1'b0, (i < 2 || i == 6) ? 1'b1 : 1'b0);
            e = exp_q.pop_front();
            n_checks++;
            if ({count, state} !== e) begin
                n_fail++;
                $display("FAIL hold[%0d]: got count=%0d state=%b expected count=%0d state=%b",
                         i, count, state, e[5:3], e[2:0]);
            end
        end
    endtask

    task automatic test_reset_mid_count();
        logic [5:0] e;
        // Count is 3 on entry; reset wins over w, then counting restarts.
        exp_q.push_back({3'd0, 3'b000});
        step(1'b1, 1'b1);
        e = exp_q.pop_front();
        n_checks++;
        if ({count, state} !== e) begin
            n_fail++;
            $display("FAIL reset_priority: got count=%0d state=%b expected count=%0d state=%b",
                     count, state, e[5:3], e[2:0]);
        end
        exp_q.push_back({3'd1, 3'b001});
        step(1'b0, 1'b1);
        e = exp_q.pop_front();
        n_checks++;
        if ({count, state} !== e) begin
            n_fail++;
            $display("FAIL resume_after_reset: got count=%0d state=%b expected count=%0d state=%b",
                     count, state, e[5:3], e[2:0]);
        end
    endtask

    task automatic test_illegal();
        logic [5:0] e;
        @(negedge clk);
        rst = 1'b0;
        w   = 1'b1;
        force dut.state_q = 3'b110;
        #1;
        exp_q.push_back({3'd0, 3'b110});
        e = exp_q.pop_front();
        n_checks++;
        if ({count, state} !== e) begin
            n_fail++;
            $display("FAIL illegal_decode: got count=%0d state=%b expected count=%0d state=%b",
                     count, state, e[5:3], e[2:0]);
        end
        release dut.state_q;
        exp_q.push_back({3'd0, 3'b000});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        n_checks++;
        if ({count, state} !== e) begin
            n_fail++;
            $display("FAIL illegal_recover: got count=%0d state=%b expected count=%0d state=%b",
                     count, state, e[5:3], e[2:0]);
        end
    endtask

    task automatic test_glitch();
        logic [5:0] e;
        step(1'b0, 1'b1);
        // w pulses between edges but is low at each rising edge.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            rst = 1'b0;
            w   = 1'b0;
            #1 w = 1'b1;
            #2 w = 1'b0;
            exp_q.push_back({3'd1, 3'b001});
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            n_checks++;
            if ({count, state} !== e) begin
                n_fail++;
                $display("FAIL glitch[%0d]: got count=%0d state=%b expected count=%0d state=%b",
                         i, count, state, e[5:3], e[2:0]);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b0;
        w        = 1'b0;
        test_reset();
        test_wrap();
        test_hold();
        test_reset_mid_count();
        test_illegal();
        test_glitch();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
